// File: rtl/core_pkg.sv
// Shared core types: instruction layout, issue classes, decode info and issue FSM states.
package core_pkg;

  localparam int unsigned CORE_XLEN  = 32;
  localparam int unsigned CORE_NREG  = 32;
  localparam int unsigned CORE_CNT_W = 16;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned OPC_W      = 7;

  typedef struct packed {
    logic [6:0]       funct7;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rs1;
    logic [2:0]       funct3;
    logic [REG_W-1:0] rd;
    logic [OPC_W-1:0] opcode;
  } instruction_t;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_LSU     = 2'd1,
    CLS_SERIAL  = 2'd2,
    CLS_ILLEGAL = 2'd3
  } issue_cls_e;

  typedef struct packed {
    issue_cls_e       cls;
    logic             use_rs1;
    logic             use_rs2;
    logic             writes_rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } dec_info_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } issue_state_e;

  localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/issue_decode.sv
// Combinational RV32I opcode classifier: issue class, register usage and register fields.
module issue_decode
  import core_pkg::*;
(
  input  instruction_t i_instr,
  output dec_info_t    o_info
);

  logic w_unused;
  assign w_unused = ^{i_instr.funct7, i_instr.funct3};

  always_comb begin
    o_info           = '0;
    o_info.cls       = CLS_ILLEGAL;
    o_info.rs1       = i_instr.rs1;
    o_info.rs2       = i_instr.rs2;
    o_info.rd        = i_instr.rd;
    case (i_instr.opcode)
      OPC_OP: begin
        o_info.cls       = CLS_ALU;
        o_info.use_rs1   = 1'b1;
        o_info.use_rs2   = 1'b1;
        o_info.writes_rd = 1'b1;
      end
      OPC_OP_IMM, OPC_JALR: begin
        o_info.cls       = CLS_ALU;
        o_info.use_rs1   = 1'b1;
        o_info.writes_rd = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        o_info.cls       = CLS_ALU;
        o_info.writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        o_info.cls     = CLS_ALU;
        o_info.use_rs1 = 1'b1;
        o_info.use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        o_info.cls       = CLS_LSU;
        o_info.use_rs1   = 1'b1;
        o_info.writes_rd = 1'b1;
      end
      OPC_STORE: begin
        o_info.cls     = CLS_LSU;
        o_info.use_rs1 = 1'b1;
        o_info.use_rs2 = 1'b1;
      end
      OPC_SYSTEM: begin
        o_info.cls       = CLS_SERIAL;
        o_info.writes_rd = 1'b1;
      end
      OPC_MISC_MEM: begin
        o_info.cls = CLS_SERIAL;
      end
      default: begin
        o_info.cls = CLS_ILLEGAL;
      end
    endcase
  end

endmodule

// File: rtl/issue_ctrl.sv
// Single-issue scheduler: holds one instruction, checks the busy scoreboard and
// dispatches to ALU or LSU; serializing/illegal ops wait for a fully drained scoreboard.
module issue_ctrl
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = CORE_XLEN,
  parameter int unsigned NREG  = CORE_NREG,
  parameter int unsigned CNT_W = CORE_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  instruction_t     in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic             lsu_valid,
  input  logic             lsu_ready,
  output logic [31:0]      iss_instr,
  output logic [XLEN-1:0]  iss_pc,
  output logic             iss_serial,
  output logic             iss_illegal,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             flush,
  output logic [NREG-1:0]  sb_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  issue_state_e     r_state;
  instruction_t     r_instr;
  logic [XLEN-1:0]  r_pc;
  dec_info_t        r_dec;
  logic [NREG-1:0]  r_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  dec_info_t        w_in_dec;
  logic [NREG-1:0]  w_wb_mask;
  logic [NREG-1:0]  w_eff;
  logic [NREG-1:0]  w_set_mask;
  logic [NREG-1:0]  w_busy_nxt;
  logic             w_hazard;
  logic             w_drained;
  logic             w_alu_valid;
  logic             w_lsu_valid;
  logic             w_fire;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_stall;

  issue_decode u_decode (
    .i_instr (in_instr),
    .o_info  (w_in_dec)
  );

  // Hazard, dispatch handshake and scoreboard update; same-cycle writeback releases hazards.
  always_comb begin
    w_wb_mask   = wb_valid ? (NREG'(1) << wb_rd) : '0;
    w_eff       = r_busy & ~w_wb_mask;
    w_hazard    = (r_dec.use_rs1   & w_eff[r_dec.rs1]) |
                  (r_dec.use_rs2   & w_eff[r_dec.rs2]) |
                  (r_dec.writes_rd & w_eff[r_dec.rd]);
    w_drained   = (w_eff == '0);
    w_alu_valid = 1'b0;
    w_lsu_valid = 1'b0;
    case (r_state)
      ST_HOLD: begin
        w_alu_valid = (r_dec.cls == CLS_ALU) & ~w_hazard & ~flush;
        w_lsu_valid = (r_dec.cls == CLS_LSU) & ~w_hazard & ~flush;
      end
      ST_DRAIN: w_alu_valid = w_drained & ~flush;
      default: ;
    endcase
    w_fire     = (w_alu_valid & alu_ready) | (w_lsu_valid & lsu_ready);
    w_in_ready = ~flush & ((r_state == ST_EMPTY) | w_fire);
    w_accept   = in_valid & w_in_ready;
    w_stall    = ~flush & (((r_state == ST_HOLD) & w_hazard) |
                           ((r_state == ST_DRAIN) & ~w_drained));
    w_set_mask = (w_fire & r_dec.writes_rd & (r_dec.rd != '0)) ?
                 (NREG'(1) << r_dec.rd) : '0;
    // Set on issue wins over a same-cycle clear of the same register.
    w_busy_nxt    = (r_busy & ~w_wb_mask) | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_instr     <= '0;
      r_pc        <= '0;
      r_dec       <= '0;
      r_busy      <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (flush) begin
        r_state <= ST_EMPTY;
      end else if (w_accept) begin
        r_state <= ((w_in_dec.cls == CLS_SERIAL) || (w_in_dec.cls == CLS_ILLEGAL)) ?
                   ST_DRAIN : ST_HOLD;
        r_instr <= in_instr;
        r_pc    <= in_pc;
        r_dec   <= w_in_dec;
      end else if (w_fire) begin
        r_state <= ST_EMPTY;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign alu_valid   = w_alu_valid;
  assign lsu_valid   = w_lsu_valid;
  assign iss_instr   = r_instr;
  assign iss_pc      = r_pc;
  assign iss_serial  = (r_dec.cls == CLS_SERIAL);
  assign iss_illegal = (r_dec.cls == CLS_ILLEGAL);
  assign sb_busy     = r_busy;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: hazard stalls, LSU backpressure, drain, flush, set/clear collision, reset.
module tb_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        alu_valid;
  logic        alu_ready;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [31:0] iss_instr;
  logic [31:0] iss_pc;
  logic        iss_serial;
  logic        iss_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] sb_busy;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] I_ADDI_X1 = 32'h0050_0093;
  localparam logic [31:0] I_ADD_X2  = 32'h0030_8133;
  localparam logic [31:0] I_LW_X5   = 32'h0003_2283;
  localparam logic [31:0] I_ADDI_X7 = 32'h0000_0393;
  localparam logic [31:0] I_ECALL   = 32'h0000_0073;
  localparam logic [31:0] I_ADDI_X9 = 32'h0000_0493;
  localparam logic [31:0] I_AMO     = 32'h0000_002F;
  localparam logic [31:0] I_ADDI_X6 = 32'h0000_0313;
  localparam logic [31:0] I_ADDI_X4 = 32'h0000_0213;
  localparam logic [31:0] I_ADDI_X0 = 32'h0000_0013;
  localparam logic [31:0] I_ADDI_X3 = 32'h0000_0193;

  issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .iss_instr   (iss_instr),
    .iss_pc      (iss_pc),
    .iss_serial  (iss_serial),
    .iss_illegal (iss_illegal),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .flush       (flush),
    .sb_busy     (sb_busy),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move one cycle on; inputs are then changed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                     input logic wv, input logic [4:0] wrd, input logic fl);
    in_valid = iv;
    in_instr = ins;
    in_pc    = pc;
    wb_valid = wv;
    wb_rd    = wrd;
    flush    = fl;
    #1;
  endtask

  initial begin
    rst = 1'b1; alu_ready = 1'b1; lsu_ready = 1'b1;
    drv(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_lsu_valid", 32'(lsu_valid), 32'd0);
    chk("rst_sb_busy", sb_busy, 32'h0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_iss_instr", iss_instr, 32'h0);
    chk("rst_iss_flags", {30'd0, iss_serial, iss_illegal}, 32'd0);

    // ADDI x1 then ADD x2,x1,x3 with writeback of x1 three cycles later
    drv(1'b1, I_ADDI_X1, 32'h100, 1'b0, 5'd0, 1'b0);
    chk("t1_accept_ready", 32'(in_ready), 32'd1);
    chk("t1_no_same_cycle_valid", 32'(alu_valid), 32'd0);
    tick();
    drv(1'b1, I_ADD_X2, 32'h104, 1'b0, 5'd0, 1'b0);
    chk("t1_addi_valid", 32'(alu_valid), 32'd1);
    chk("t1_addi_instr", iss_instr, I_ADDI_X1);
    chk("t1_addi_pc", iss_pc, 32'h100);
    chk("t1_b2b_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      drv(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
      chk("t1_add_stalled", 32'(alu_valid), 32'd0);
      chk("t1_stall_ready", 32'(in_ready), 32'd0);
    end
    chk("t1_busy_x1", sb_busy, 32'h2);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b1, 5'd1, 1'b0);
    chk("t1_add_wb_issue", 32'(alu_valid), 32'd1);
    chk("t1_add_instr", iss_instr, I_ADD_X2);
    chk("t1_stall3", 32'(stall_cnt), 32'd3);
    tick();

    // LW x5 under LSU backpressure; clear x2 in the same cycle it is accepted
    lsu_ready = 1'b0;
    drv(1'b1, I_LW_X5, 32'h200, 1'b1, 5'd2, 1'b0);
    chk("t1_busy_after", sb_busy, 32'h4);
    chk("t1_empty_after", 32'(alu_valid), 32'd0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("t2_lsu_valid_c1", 32'(lsu_valid), 32'd1);
    chk("t2_alu_quiet", 32'(alu_valid), 32'd0);
    chk("t2_instr_c1", iss_instr, I_LW_X5);
    chk("t2_busy_clear", sb_busy, 32'h0);
    tick();
    chk("t2_lsu_valid_c2", 32'(lsu_valid), 32'd1);
    chk("t2_instr_c2", iss_instr, I_LW_X5);
    chk("t2_not_ready", 32'(in_ready), 32'd0);
    tick();
    lsu_ready = 1'b1;
    #1;
    chk("t2_lsu_valid_c3", 32'(lsu_valid), 32'd1);
    chk("t2_fire_ready", 32'(in_ready), 32'd1);
    tick();
    chk("t2_busy_x5", sb_busy, 32'h20);
    chk("t2_stall_unchanged", 32'(stall_cnt), 32'd3);
    chk("t2_lsu_done", 32'(lsu_valid), 32'd0);

    // ECALL waits in drain while x5/x7 are busy
    drv(1'b1, I_ADDI_X7, 32'h300, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b1, I_ECALL, 32'h304, 1'b0, 5'd0, 1'b0);
    chk("t3_addi7_valid", 32'(alu_valid), 32'd1);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0);
    chk("t3_busy_57", sb_busy, 32'hA0);
    chk("t3_drain_hold", 32'(alu_valid), 32'd0);
    chk("t3_serial", 32'(iss_serial), 32'd1);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b1, 5'd7, 1'b0);
    chk("t3_ecall_issue", 32'(alu_valid), 32'd1);
    chk("t3_ecall_instr", iss_instr, I_ECALL);
    chk("t3_stall4", 32'(stall_cnt), 32'd4);
    chk("t3_not_illegal", 32'(iss_illegal), 32'd0);
    tick();

    // AMO opcode is illegal and issues on the ALU only once drained
    drv(1'b1, I_ADDI_X9, 32'h400, 1'b0, 5'd0, 1'b0);
    chk("t4_busy_empty", sb_busy, 32'h0);
    tick();
    drv(1'b1, I_AMO, 32'h404, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("t4_busy_x9", sb_busy, 32'h200);
    chk("t4_amo_wait", 32'(alu_valid), 32'd0);
    chk("t4_illegal", 32'(iss_illegal), 32'd1);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b1, 5'd9, 1'b0);
    chk("t4_amo_issue", 32'(alu_valid), 32'd1);
    chk("t4_amo_lsu_quiet", 32'(lsu_valid), 32'd0);
    tick();

    // Flush of a hazard-blocked LW keeps the scoreboard
    drv(1'b1, I_ADDI_X6, 32'h500, 1'b0, 5'd0, 1'b0);
    chk("t5_stall5", 32'(stall_cnt), 32'd5);
    tick();
    drv(1'b1, I_LW_X5, 32'h504, 1'b0, 5'd0, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("t5_lw_blocked", 32'(lsu_valid), 32'd0);
    tick();
    drv(1'b1, I_ADDI_X4, 32'h508, 1'b0, 5'd0, 1'b1);
    chk("t5_flush_ready", 32'(in_ready), 32'd0);
    chk("t5_flush_lsu", 32'(lsu_valid), 32'd0);
    tick();
    drv(1'b1, I_ADDI_X4, 32'h508, 1'b1, 5'd6, 1'b0);
    chk("t5_empty_ready", 32'(in_ready), 32'd1);
    chk("t5_busy_kept", sb_busy, 32'h40);
    chk("t5_no_issue", {30'd0, alu_valid, lsu_valid}, 32'd0);
    chk("t5_stall6", 32'(stall_cnt), 32'd6);
    tick();

    // Issue of x4 collides with a writeback of x4: set wins; x0 never busy
    drv(1'b0, 32'h0, 32'h0, 1'b1, 5'd4, 1'b0);
    chk("t6_addi4_valid", 32'(alu_valid), 32'd1);
    tick();
    drv(1'b1, I_ADDI_X0, 32'h600, 1'b1, 5'd4, 1'b0);
    chk("t6_busy_x4", sb_busy, 32'h10);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 1'b0);
    chk("t6_addi0_valid", 32'(alu_valid), 32'd1);
    tick();
    drv(1'b1, I_ADDI_X3, 32'h700, 1'b0, 5'd0, 1'b0);
    chk("t6_busy_x0", sb_busy, 32'h0);
    tick();
    drv(1'b1, I_ADDI_X1, 32'h704, 1'b0, 5'd0, 1'b0);
    tick();

    // Reset while an instruction is held
    alu_ready = 1'b0;
    drv(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    chk("t7_held_valid", 32'(alu_valid), 32'd1);
    chk("t7_busy_x3", sb_busy, 32'h8);
    rst = 1'b1;
    tick();
    chk("t7_alu_valid", 32'(alu_valid), 32'd0);
    chk("t7_lsu_valid", 32'(lsu_valid), 32'd0);
    chk("t7_iss_instr", iss_instr, 32'h0);
    chk("t7_iss_pc", iss_pc, 32'h0);
    chk("t7_sb_busy", sb_busy, 32'h0);
    chk("t7_stall", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("t7_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
